// File: rtl/sha512_digest_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : sha512_digest_streamer_if
// Description : Byte-stream bus (valid/ready) carrying digest frames, with
//               per-frame id and message length sidebands.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha512_digest_streamer_if;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] m_tid;
    logic [60:0] m_tlen;
    logic [7:0]  m_tdata;

    modport master (
        output m_tvalid, m_tlast, m_tid, m_tlen, m_tdata,
        input  m_tready
    );

    modport slave (
        input  m_tvalid, m_tlast, m_tid, m_tlen, m_tdata,
        output m_tready
    );
endinterface
`default_nettype wire

// File: rtl/sha512_digest_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sha512_digest_streamer
// Description : Captures one-cycle sha512 results into a small FIFO and
//               re-emits each digest as a byte stream, either raw (64 bytes)
//               or lowercase ASCII hex (128 chars), MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_digest_streamer #(
    parameter int DEPTH = 2,
    parameter bit HEX   = 1'b0
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          i_valid,
    input  wire  [31:0]  i_id,
    input  wire  [60:0]  i_len,
    input  wire  [511:0] i_sha,
    sha512_digest_streamer_if.master m_axis,
    output logic         overflow,
    output logic [15:0]  drop_cnt
);

    localparam int          c_AW      = $clog2(DEPTH);
    localparam int          c_EW      = 32 + 61 + 512;
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [6:0]  c_LAST    = HEX ? 7'd127 : 7'd63;

    localparam logic [0:0]  c_S_IDLE  = 1'b0;
    localparam logic [0:0]  c_S_SEND  = 1'b1;

    // FIFO storage and pointers; the extra MSB distinguishes full from empty
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;

    // Frame register
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [511:0]    r_sha;
    logic [31:0]     r_tid;
    logic [60:0]     r_tlen;
    logic [6:0]      r_cnt;
    logic            w_send;
    logic            w_hs;
    logic            w_last;
    logic            w_shift;
    logic [3:0]      w_nib;
    logic [7:0]      w_hex;
    logic [7:0]      w_sym;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // A full FIFO still accepts a result if a slot frees in the same cycle
    assign w_push  = i_valid && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_send  = (r_state == c_S_SEND);
    assign w_hs    = w_send && m_axis.m_tready;
    assign w_last  = (r_cnt == c_LAST);
    // In hex mode a byte leaves the shifter only after its low-nibble char
    assign w_shift = HEX ? r_cnt[0] : 1'b1;

    assign w_nib   = r_cnt[0] ? r_sha[507:504] : r_sha[511:508];
    assign w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                     : (8'h57 + {4'h0, w_nib});
    assign w_sym   = HEX ? w_hex : r_sha[511:504];

    assign m_axis.m_tvalid = w_send;
    assign m_axis.m_tlast  = w_send && w_last;
    assign m_axis.m_tdata  = w_send ? w_sym : 8'h00;
    assign m_axis.m_tid    = r_tid;
    assign m_axis.m_tlen   = r_tlen;

    // Write accepted results into the FIFO (storage needs no reset)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {i_id, i_len, i_sha};
        end
    end

    // Advance FIFO pointers on push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Track dropped results: sticky flag plus saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 16'h0000;
        end else if (i_valid && !w_push) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_S_SEND;
                end
            end
            c_S_SEND: begin
                if (w_hs && w_last) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Load a popped result into the frame register and walk its symbols
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sha  <= '0;
            r_tid  <= '0;
            r_tlen <= '0;
            r_cnt  <= '0;
        end else if (w_pop) begin
            r_tid  <= w_head[c_EW-1 -: 32];
            r_tlen <= w_head[511+61 -: 61];
            r_sha  <= w_head[511:0];
            r_cnt  <= '0;
        end else if (w_hs) begin
            r_cnt <= r_cnt + 7'd1;
            if (w_shift) r_sha <= {r_sha[503:0], 8'h00};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha512_digest_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha512_digest_streamer
// Description : Directed, table-driven bench for sha512_digest_streamer with
//               a raw-byte instance and an ASCII-hex instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha512_digest_streamer;

    localparam logic [511:0] c_ABC =
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

    typedef struct {
        logic [7:0]  d;
        logic        last;
        logic [31:0] id;
        logic [60:0] len;
    } sym_t;

    typedef struct {
        bit         hex;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic [31:0]  i_id;
    logic [60:0]  i_len;
    logic [511:0] i_sha;
    logic         rdy_raw;
    logic         rdy_hex;
    logic         ovf_raw, ovf_hex;
    logic [15:0]  dc_raw, dc_hex;

    int n_checks;
    int n_errors;

    sym_t q_raw[$];
    sym_t q_hex[$];
    vec_t vecs[12];

    // stall-hold monitor state
    bit          stall_prev;
    logic [7:0]  p_d;
    logic        p_last;
    logic [31:0] p_id;
    logic [60:0] p_len;

    sha512_digest_streamer_if if_raw ();
    sha512_digest_streamer_if if_hex ();

    assign if_raw.m_tready = rdy_raw;
    assign if_hex.m_tready = rdy_hex;

    sha512_digest_streamer #(.DEPTH(2), .HEX(1'b0)) u_raw (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_id(i_id), .i_len(i_len),
        .i_sha(i_sha), .m_axis(if_raw), .overflow(ovf_raw), .drop_cnt(dc_raw)
    );

    sha512_digest_streamer #(.DEPTH(2), .HEX(1'b1)) u_hex (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_id(i_id), .i_len(i_len),
        .i_sha(i_sha), .m_axis(if_hex), .overflow(ovf_hex), .drop_cnt(dc_hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect handshaked symbols and verify outputs hold while stalled
    always @(negedge clk) begin
        if (!rst && if_raw.m_tvalid && if_raw.m_tready)
            q_raw.push_back('{if_raw.m_tdata, if_raw.m_tlast, if_raw.m_tid, if_raw.m_tlen});
        if (!rst && if_hex.m_tvalid && if_hex.m_tready)
            q_hex.push_back('{if_hex.m_tdata, if_hex.m_tlast, if_hex.m_tid, if_hex.m_tlen});
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (!(if_raw.m_tvalid && if_raw.m_tdata == p_d && if_raw.m_tlast == p_last &&
                      if_raw.m_tid == p_id && if_raw.m_tlen == p_len)) begin
                    n_errors++;
                    $display("FAIL stall_hold: got v=%0b d=%02h l=%0b id=%0d, required v=1 d=%02h l=%0b id=%0d",
                             if_raw.m_tvalid, if_raw.m_tdata, if_raw.m_tlast, if_raw.m_tid,
                             p_d, p_last, p_id);
                end
            end
            stall_prev = if_raw.m_tvalid && !if_raw.m_tready;
            p_d    = if_raw.m_tdata;
            p_last = if_raw.m_tlast;
            p_id   = if_raw.m_tid;
            p_len  = if_raw.m_tlen;
        end
    end

    function automatic logic [7:0] exp_sym(input logic [511:0] sha, input int k, input bit hex);
        logic [7:0] b;
        logic [7:0] n;
        if (!hex) return sha[511-8*k -: 8];
        b = sha[511-8*(k/2) -: 8];
        n = (k % 2 == 1) ? {4'h0, b[3:0]} : {4'h0, b[7:4]};
        return (n < 8'd10) ? 8'h30 + n : 8'h61 + n - 8'd10;
    endfunction

    function automatic logic [511:0] pat(input logic [7:0] seed);
        logic [511:0] s;
        for (int k = 0; k < 64; k++) s[511-8*k -: 8] = seed * 8'd37 + k[7:0] * 8'd11;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        q_raw.delete();
        q_hex.delete();
        tick();
    endtask

    // Assert one result strobe for the current cycle
    task automatic send(input logic [31:0] id, input logic [60:0] len, input logic [511:0] sha);
        i_valid = 1'b1;
        i_id    = id;
        i_len   = len;
        i_sha   = sha;
        tick();
        i_valid = 1'b0;
        i_sha   = '0;
    endtask

    task automatic wait_bytes(input bit hex, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if ((hex ? q_hex.size() : q_raw.size()) >= n) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk(hex ? "hex_byte_count_timeout" : "raw_byte_count_timeout", {63'd0, ok}, 64'd1);
    endtask

    // Compare one full frame in the capture queue against the model
    task automatic check_frame(input bit hex, input int base, input logic [31:0] id,
                               input logic [60:0] len, input logic [511:0] sha);
        int nsym, bad_d, bad_l, bad_s, sz;
        sym_t s;
        nsym = hex ? 128 : 64;
        sz = hex ? q_hex.size() : q_raw.size();
        bad_d = 0; bad_l = 0; bad_s = 0;
        for (int k = 0; k < nsym; k++) begin
            if (base + k >= sz) begin
                bad_d++;
                continue;
            end
            s = hex ? q_hex[base+k] : q_raw[base+k];
            if (s.d !== exp_sym(sha, k, hex)) bad_d++;
            if (s.last !== (k == nsym - 1)) bad_l++;
            if (s.id !== id || s.len !== len) bad_s++;
        end
        chk($sformatf("frame_data id=%0d", id), 64'(bad_d), 64'd0);
        chk($sformatf("frame_tlast id=%0d", id), 64'(bad_l), 64'd0);
        chk($sformatf("frame_id_len id=%0d", id), 64'(bad_s), 64'd0);
    endtask

    task automatic apply_table(input bit hex);
        int sz;
        sz = hex ? q_hex.size() : q_raw.size();
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].hex != hex) continue;
            if (vecs[i].idx >= sz) chk($sformatf("vec%0d_missing", i), 64'(sz), 64'(vecs[i].idx + 1));
            else chk($sformatf("vec%0d_byte%0d", i, vecs[i].idx),
                     hex ? 64'(q_hex[vecs[i].idx].d) : 64'(q_raw[vecs[i].idx].d),
                     64'(vecs[i].exp));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        stall_prev = 1'b0;
        i_valid = 1'b0;
        i_id = '0;
        i_len = '0;
        i_sha = '0;
        rdy_raw = 1'b1;
        rdy_hex = 1'b1;
        rst = 1'b1;

        vecs[0]  = '{1'b0, 0,   8'hdd};
        vecs[1]  = '{1'b0, 1,   8'haf};
        vecs[2]  = '{1'b0, 2,   8'h35};
        vecs[3]  = '{1'b0, 3,   8'ha1};
        vecs[4]  = '{1'b0, 59,  8'h4f};
        vecs[5]  = '{1'b0, 60,  8'ha5};
        vecs[6]  = '{1'b0, 63,  8'h9f};
        vecs[7]  = '{1'b1, 0,   8'h64};
        vecs[8]  = '{1'b1, 1,   8'h64};
        vecs[9]  = '{1'b1, 2,   8'h61};
        vecs[10] = '{1'b1, 126, 8'h39};
        vecs[11] = '{1'b1, 127, 8'h66};

        // Reset state
        tick();
        chk("rst_tvalid", 64'(if_raw.m_tvalid), 64'd0);
        chk("rst_tlast",  64'(if_raw.m_tlast),  64'd0);
        chk("rst_tid",    64'(if_raw.m_tid),    64'd0);
        chk("rst_tlen",   64'(if_raw.m_tlen),   64'd0);
        chk("rst_tdata",  64'(if_raw.m_tdata),  64'd0);
        chk("rst_hex_tdata", 64'(if_hex.m_tdata), 64'd0);
        chk("rst_overflow", 64'(ovf_raw), 64'd0);
        chk("rst_drop_cnt", 64'(dc_raw), 64'd0);
        rst = 1'b0;
        tick();

        // "abc" raw with latency check
        send(32'd5, 61'd3, c_ABC);
        chk("lat_n1_tvalid", 64'(if_raw.m_tvalid), 64'd0);
        tick();
        chk("lat_n2_tvalid", 64'(if_raw.m_tvalid), 64'd1);
        chk("lat_n2_tdata",  64'(if_raw.m_tdata),  64'hdd);
        chk("lat_n2_tid",    64'(if_raw.m_tid),    64'd5);
        chk("lat_n2_tlen",   64'(if_raw.m_tlen),   64'd3);
        chk("lat_n2_hex_tdata", 64'(if_hex.m_tdata), 64'h64);
        wait_bytes(1'b0, 64);
        wait_bytes(1'b1, 128);
        repeat (5) tick();
        chk("abc_raw_count", 64'(q_raw.size()), 64'd64);
        chk("abc_hex_count", 64'(q_hex.size()), 64'd128);
        apply_table(1'b0);
        apply_table(1'b1);
        check_frame(1'b0, 0, 32'd5, 61'd3, c_ABC);
        check_frame(1'b1, 0, 32'd5, 61'd3, c_ABC);

        // Random backpressure on the raw instance
        do_reset();
        send(32'd5, 61'd3, c_ABC);
        for (int c = 0; c < 2000 && q_raw.size() < 64; c++) begin
            rdy_raw = ($urandom_range(0, 1) == 1);
            tick();
        end
        rdy_raw = 1'b1;
        repeat (5) tick();
        chk("rand_rdy_count", 64'(q_raw.size()), 64'd64);
        check_frame(1'b0, 0, 32'd5, 61'd3, c_ABC);

        // Overflow: four results, sink stalled
        do_reset();
        rdy_raw = 1'b0;
        send(32'd1, 61'd10, pat(8'd1)); tick();
        send(32'd2, 61'd20, pat(8'd2)); tick();
        send(32'd3, 61'd30, pat(8'd3)); tick();
        send(32'd4, 61'd40, pat(8'd4)); tick();
        chk("ovf_flag", 64'(ovf_raw), 64'd1);
        chk("ovf_drop_cnt", 64'(dc_raw), 64'd1);
        rdy_raw = 1'b1;
        wait_bytes(1'b0, 192);
        repeat (300) tick();
        chk("ovf_total_bytes", 64'(q_raw.size()), 64'd192);
        check_frame(1'b0, 0,   32'd1, 61'd10, pat(8'd1));
        check_frame(1'b0, 64,  32'd2, 61'd20, pat(8'd2));
        check_frame(1'b0, 128, 32'd3, 61'd30, pat(8'd3));
        chk("ovf_flag_sticky", 64'(ovf_raw), 64'd1);

        // Full FIFO with a push in the same cycle as a pop
        do_reset();
        rdy_raw = 1'b0;
        send(32'd1, 61'd11, pat(8'd11)); tick();
        send(32'd2, 61'd12, pat(8'd12));
        send(32'd3, 61'd13, pat(8'd13));
        rdy_raw = 1'b1;
        wait_bytes(1'b0, 64);
        send(32'd4, 61'd14, pat(8'd14));
        wait_bytes(1'b0, 256);
        repeat (5) tick();
        chk("fullpop_overflow", 64'(ovf_raw), 64'd0);
        chk("fullpop_drop_cnt", 64'(dc_raw), 64'd0);
        chk("fullpop_bytes", 64'(q_raw.size()), 64'd256);
        check_frame(1'b0, 0,   32'd1, 61'd11, pat(8'd11));
        check_frame(1'b0, 64,  32'd2, 61'd12, pat(8'd12));
        check_frame(1'b0, 128, 32'd3, 61'd13, pat(8'd13));
        check_frame(1'b0, 192, 32'd4, 61'd14, pat(8'd14));

        // Reset in the middle of a frame
        do_reset();
        send(32'd7, 61'd77, pat(8'd7));
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (q_raw.size() >= 10) break;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(if_raw.m_tvalid), 64'd0);
        chk("midrst_tlast",  64'(if_raw.m_tlast),  64'd0);
        chk("midrst_tid",    64'(if_raw.m_tid),    64'd0);
        chk("midrst_tlen",   64'(if_raw.m_tlen),   64'd0);
        chk("midrst_tdata",  64'(if_raw.m_tdata),  64'd0);
        chk("midrst_bytes_before", 64'(q_raw.size()), 64'd10);
        tick();
        tick();
        rst = 1'b0;
        q_raw.delete();
        q_hex.delete();
        tick();
        send(32'd9, 61'd3, c_ABC);
        wait_bytes(1'b0, 64);
        repeat (100) tick();
        chk("midrst_new_count", 64'(q_raw.size()), 64'd64);
        check_frame(1'b0, 0, 32'd9, 61'd3, c_ABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
